// File: rtl/filter_frame_sequencer.sv
// filter_frame_sequencer
// Frame-level controller for the streaming KxK line-buffer filter. Reads one
// WIDTHxHEIGHT RGB frame from pixel memory through a small credit-limited
// read-return FIFO. Streams it to the filter with B=(KERNEL_SIZE-1)/2 zero
// rows and columns of padding, followed by FLUSH_PIXELS drain zeros. Turns
// the filter's results into sequential memory writes.
// Optional feature macro: FILTER_SEQ_STALL_CNT_EN adds oStallCnt, which
// counts the ROW_PIX cycles spent waiting on an empty FIFO.
module filter_frame_sequencer #(
    parameter int WIDTH        = 320,
    parameter int HEIGHT       = 240,
    parameter int KERNEL_SIZE  = 3,
    parameter int FLUSH_PIXELS = 16,
    parameter int RD_DEPTH     = 4,
    parameter int ADDR_W       = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              iStart,
    input  logic [ADDR_W-1:0] iRdBase,
    input  logic [ADDR_W-1:0] iWrBase,
    output logic              oRdReq,
    output logic [ADDR_W-1:0] oRdAddr,
    input  logic              iRdValid,
    input  logic [23:0]       iRdData,
    output logic              oFiltValid,
    output logic [23:0]       oFiltData,
    input  logic              iFiltValid,
    input  logic [23:0]       iFiltData,
    output logic              oWrReq,
    output logic [ADDR_W-1:0] oWrAddr,
    output logic [23:0]       oWrData,
    output logic              oBusy,
    output logic              oDone
`ifdef FILTER_SEQ_STALL_CNT_EN
    ,
    output logic [31:0]       oStallCnt
`endif
);

    localparam int B       = (KERNEL_SIZE - 1) / 2;
    localparam int N_PIX   = WIDTH * HEIGHT;
    localparam int ROW_LEN = WIDTH + 2 * B;
    localparam int CNT_MAX = (ROW_LEN > FLUSH_PIXELS) ? ROW_LEN : FLUSH_PIXELS;
    localparam int ROW_MAX = (HEIGHT > B) ? HEIGHT : B;
    localparam int PIX_W   = $clog2(N_PIX + 1);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int ROW_W   = $clog2(ROW_MAX + 1);
    localparam int PTR_W   = $clog2(RD_DEPTH);
    localparam int OCC_W   = $clog2(RD_DEPTH + 1);
    localparam int SUM_W   = OCC_W + 1;

    localparam logic [CNT_W-1:0] ROW_LAST   = CNT_W'(ROW_LEN - 1);
    localparam logic [CNT_W-1:0] PIX_LAST   = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] PAD_LAST   = CNT_W'((B > 0) ? B - 1 : 0);
    localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'((FLUSH_PIXELS > 0) ? FLUSH_PIXELS - 1 : 0);
    localparam logic [ROW_W-1:0] ROWS_LAST  = ROW_W'(HEIGHT - 1);
    localparam logic [ROW_W-1:0] BROWS_LAST = ROW_W'((B > 0) ? B - 1 : 0);
    localparam logic [PIX_W-1:0] N_PIX_C    = PIX_W'(N_PIX);
    localparam logic [SUM_W-1:0] CREDIT_LIM = SUM_W'(RD_DEPTH);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_TOP_PAD  = 3'd1;
    localparam logic [2:0] S_ROW_LPAD = 3'd2;
    localparam logic [2:0] S_ROW_PIX  = 3'd3;
    localparam logic [2:0] S_ROW_RPAD = 3'd4;
    localparam logic [2:0] S_BOT_PAD  = 3'd5;
    localparam logic [2:0] S_FLUSH    = 3'd6;
    localparam logic [2:0] S_WAIT_WR  = 3'd7;

    // Padding-dependent successors; with B=0 the pad states are never entered.
    localparam logic [2:0] FIRST_ST = (B > 0) ? S_TOP_PAD : S_ROW_PIX;
    localparam logic [2:0] DRAIN_ST = (FLUSH_PIXELS > 0) ? S_FLUSH : S_WAIT_WR;
    localparam logic [2:0] ROWS_END = (B > 0) ? S_BOT_PAD : DRAIN_ST;
    localparam logic [2:0] NEXT_ROW = (B > 0) ? S_ROW_LPAD : S_ROW_PIX;

    logic [2:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [PIX_W-1:0]  rd_idx_q, rd_idx_d;
    logic [PIX_W-1:0]  wr_cnt_q, wr_cnt_d;
    logic [ADDR_W-1:0] rd_base_q, rd_base_d;
    logic [ADDR_W-1:0] wr_base_q, wr_base_d;
    logic [OCC_W-1:0]  out_q, out_d;
    logic [OCC_W-1:0]  occ_q, occ_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic              wr_req_q, wr_req_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [23:0]       wr_data_q, wr_data_d;
    logic [23:0]       fifo_mem_q [RD_DEPTH];

    logic start_acc;
    logic busy_st;
    logic pad_st;
    logic fifo_empty;
    logic push;
    logic pop;
    logic rd_req;
    logic wr_fire;
    logic done;
    logic row_done;

    // Handshake decode shared by the FSM, read issuer, FIFO and write path.
    always_comb begin
        start_acc  = (state_q == S_IDLE) && iStart;
        busy_st    = (state_q != S_IDLE);
        pad_st     = (state_q == S_TOP_PAD) || (state_q == S_ROW_LPAD) ||
                     (state_q == S_ROW_RPAD) || (state_q == S_BOT_PAD) ||
                     (state_q == S_FLUSH);
        fifo_empty = (occ_q == '0);
        pop        = (state_q == S_ROW_PIX) && !fifo_empty;
        push       = iRdValid && busy_st;
        // Outstanding reads plus buffered pixels never exceed the FIFO depth,
        // so every returned pixel is guaranteed a slot.
        rd_req     = busy_st && (rd_idx_q != N_PIX_C) &&
                     (({1'b0, out_q} + {1'b0, occ_q}) < CREDIT_LIM);
        wr_fire    = busy_st && iFiltValid && (wr_cnt_q != N_PIX_C);
        done       = (state_q == S_WAIT_WR) && (wr_cnt_q == N_PIX_C);
        row_done   = (row_q == ROWS_LAST);
    end

    // Frame sequencing FSM: walks pad rows, padded pixel rows, then flush.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        row_d   = row_q;
        case (state_q)
            S_IDLE: begin
                if (iStart) begin
                    cnt_d   = '0;
                    row_d   = '0;
                    state_d = FIRST_ST;
                end
            end
            S_TOP_PAD: begin
                if (cnt_q == ROW_LAST) begin
                    cnt_d = '0;
                    if (row_q == BROWS_LAST) begin
                        row_d   = '0;
                        state_d = S_ROW_LPAD;
                    end else begin
                        row_d = row_q + ROW_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_ROW_LPAD: begin
                if (cnt_q == PAD_LAST) begin
                    cnt_d   = '0;
                    state_d = S_ROW_PIX;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_ROW_PIX: begin
                if (pop) begin
                    if (cnt_q == PIX_LAST) begin
                        cnt_d = '0;
                        if (B > 0) begin
                            state_d = S_ROW_RPAD;
                        end else if (row_done) begin
                            row_d   = '0;
                            state_d = ROWS_END;
                        end else begin
                            row_d   = row_q + ROW_W'(1);
                            state_d = NEXT_ROW;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            S_ROW_RPAD: begin
                if (cnt_q == PAD_LAST) begin
                    cnt_d = '0;
                    if (row_done) begin
                        row_d   = '0;
                        state_d = ROWS_END;
                    end else begin
                        row_d   = row_q + ROW_W'(1);
                        state_d = NEXT_ROW;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_BOT_PAD: begin
                if (cnt_q == ROW_LAST) begin
                    cnt_d = '0;
                    if (row_q == BROWS_LAST) begin
                        row_d   = '0;
                        state_d = DRAIN_ST;
                    end else begin
                        row_d = row_q + ROW_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_FLUSH: begin
                if (cnt_q == FLUSH_LAST) begin
                    cnt_d   = '0;
                    state_d = S_WAIT_WR;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_WAIT_WR: begin
                if (done) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Read issuer, FIFO bookkeeping and write path next-state.
    always_comb begin
        rd_base_d = start_acc ? iRdBase : rd_base_q;
        wr_base_d = start_acc ? iWrBase : wr_base_q;

        rd_idx_d = rd_idx_q;
        if (start_acc) begin
            rd_idx_d = '0;
        end else if (rd_req) begin
            rd_idx_d = rd_idx_q + PIX_W'(1);
        end

        out_d = out_q;
        case ({rd_req, push})
            2'b10:   out_d = out_q + OCC_W'(1);
            2'b01:   out_d = out_q - OCC_W'(1);
            default: out_d = out_q;
        endcase

        occ_d = occ_q;
        case ({push, pop})
            2'b10:   occ_d = occ_q + OCC_W'(1);
            2'b01:   occ_d = occ_q - OCC_W'(1);
            default: occ_d = occ_q;
        endcase

        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

        wr_cnt_d = wr_cnt_q;
        if (start_acc) begin
            wr_cnt_d = '0;
        end else if (wr_fire) begin
            wr_cnt_d = wr_cnt_q + PIX_W'(1);
        end

        wr_req_d  = wr_fire;
        wr_addr_d = wr_fire ? wr_base_q + ADDR_W'(wr_cnt_q) : wr_addr_q;
        wr_data_d = wr_fire ? iFiltData : wr_data_q;
    end

    // State registers; reset aborts any frame in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            row_q     <= '0;
            rd_idx_q  <= '0;
            wr_cnt_q  <= '0;
            rd_base_q <= '0;
            wr_base_q <= '0;
            out_q     <= '0;
            occ_q     <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            wr_req_q  <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            row_q     <= row_d;
            rd_idx_q  <= rd_idx_d;
            wr_cnt_q  <= wr_cnt_d;
            rd_base_q <= rd_base_d;
            wr_base_q <= wr_base_d;
            out_q     <= out_d;
            occ_q     <= occ_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_req_q  <= wr_req_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    // Read-return FIFO storage; contents are only trusted while occupancy says so.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem_q[wr_ptr_q] <= iRdData;
        end
    end

`ifdef FILTER_SEQ_STALL_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    // Stall counter next-state: empty-FIFO cycles inside ROW_PIX, held after the frame.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (start_acc) begin
            stall_cnt_d = '0;
        end else if ((state_q == S_ROW_PIX) && fifo_empty) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    // Stall counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign oStallCnt = stall_cnt_q;
`endif

    assign oRdReq     = rd_req;
    assign oRdAddr    = rd_req ? rd_base_q + ADDR_W'(rd_idx_q) : '0;
    assign oFiltValid = pad_st || pop;
    assign oFiltData  = pop ? fifo_mem_q[rd_ptr_q] : 24'd0;
    assign oWrReq     = wr_req_q;
    assign oWrAddr    = wr_addr_q;
    assign oWrData    = wr_data_q;
    assign oBusy      = busy_st && !done;
    assign oDone      = done;

endmodule

// File: tb/tb_filter_frame_sequencer.sv
// Testbench for filter_frame_sequencer: a K=3 and a K=1 instance share the
// memory and filter models; a select picks which one the current test drives.
`timescale 1ns/1ps
module tb_filter_frame_sequencer;
    localparam int W   = 4;
    localparam int H   = 3;
    localparam int FL  = 5;
    localparam int RDD = 4;
    localparam int AW  = 32;
    localparam int NP  = W * H;
    localparam int FILT_OUTS = NP + 2;

    logic          clk;
    logic          reset;
    logic          start_a, start_b;
    logic [AW-1:0] rd_base_in, wr_base_in;
    logic          rd_valid;
    logic [23:0]   rd_data;
    logic          filt_valid;
    logic [23:0]   filt_data;

    logic a_rdreq, a_fvalid, a_wrreq, a_busy, a_done;
    logic b_rdreq, b_fvalid, b_wrreq, b_busy, b_done;
    logic [AW-1:0] a_rdaddr, a_wraddr, b_rdaddr, b_wraddr;
    logic [23:0]   a_fdata, a_wrdata, b_fdata, b_wrdata;
    logic m_rdreq, m_fvalid, m_wrreq, m_busy, m_done;
    logic [AW-1:0] m_rdaddr, m_wraddr;
    logic [23:0]   m_fdata, m_wrdata;
`ifdef FILTER_SEQ_STALL_CNT_EN
    logic [31:0] a_stall, b_stall, m_stall;
`endif
    bit sel;

    filter_frame_sequencer #(.WIDTH(W), .HEIGHT(H), .KERNEL_SIZE(3), .FLUSH_PIXELS(FL),
                             .RD_DEPTH(RDD), .ADDR_W(AW)) u_k3 (
        .clk(clk), .reset(reset), .iStart(start_a), .iRdBase(rd_base_in), .iWrBase(wr_base_in),
        .oRdReq(a_rdreq), .oRdAddr(a_rdaddr), .iRdValid(rd_valid), .iRdData(rd_data),
        .oFiltValid(a_fvalid), .oFiltData(a_fdata), .iFiltValid(filt_valid), .iFiltData(filt_data),
        .oWrReq(a_wrreq), .oWrAddr(a_wraddr), .oWrData(a_wrdata), .oBusy(a_busy), .oDone(a_done)
`ifdef FILTER_SEQ_STALL_CNT_EN
        , .oStallCnt(a_stall)
`endif
    );

    filter_frame_sequencer #(.WIDTH(W), .HEIGHT(H), .KERNEL_SIZE(1), .FLUSH_PIXELS(FL),
                             .RD_DEPTH(RDD), .ADDR_W(AW)) u_k1 (
        .clk(clk), .reset(reset), .iStart(start_b), .iRdBase(rd_base_in), .iWrBase(wr_base_in),
        .oRdReq(b_rdreq), .oRdAddr(b_rdaddr), .iRdValid(rd_valid), .iRdData(rd_data),
        .oFiltValid(b_fvalid), .oFiltData(b_fdata), .iFiltValid(filt_valid), .iFiltData(filt_data),
        .oWrReq(b_wrreq), .oWrAddr(b_wraddr), .oWrData(b_wrdata), .oBusy(b_busy), .oDone(b_done)
`ifdef FILTER_SEQ_STALL_CNT_EN
        , .oStallCnt(b_stall)
`endif
    );

    always_comb begin
        m_rdreq  = sel ? b_rdreq  : a_rdreq;
        m_rdaddr = sel ? b_rdaddr : a_rdaddr;
        m_fvalid = sel ? b_fvalid : a_fvalid;
        m_fdata  = sel ? b_fdata  : a_fdata;
        m_wrreq  = sel ? b_wrreq  : a_wrreq;
        m_wraddr = sel ? b_wraddr : a_wraddr;
        m_wrdata = sel ? b_wrdata : a_wrdata;
        m_busy   = sel ? b_busy   : a_busy;
        m_done   = sel ? b_done   : a_done;
`ifdef FILTER_SEQ_STALL_CNT_EN
        m_stall  = sel ? b_stall  : a_stall;
`endif
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;
    int cyc, mem_lat, outstanding, fe_start;
    int n_filt, n_rd, n_wr, n_done, n_fo, n_gap;
    logic [AW-1:0] cur_wr_base;
    int            mem_due[$];
    logic [AW-1:0] mem_addr[$];
    logic [23:0]   exp_filt[$];
    bit            exp_pix[$];
    logic [AW-1:0] exp_rd[$];
    logic [AW-1:0] exp_wa[$];
    logic [23:0]   exp_wd[$];

    function automatic logic [23:0] pix_of(input logic [AW-1:0] a);
        return {a[7:0] ^ 8'hC3, a[15:8] ^ 8'h5A, a[7:0] + 8'h11};
    endfunction

    // Memory, filter and output monitors: sample DUT outputs, then drive inputs, at negedge.
    initial begin
        cyc = 0; outstanding = 0;
        rd_valid = 1'b0; rd_data = '0; filt_valid = 1'b0; filt_data = '0;
        forever begin
            @(negedge clk);
            cyc++;
            rd_valid   = 1'b0;
            filt_valid = 1'b0;
            if (reset) begin
                mem_due.delete();
                mem_addr.delete();
                outstanding = 0;
            end else begin
                if (mem_due.size() > 0 && mem_due[0] <= cyc) begin
                    rd_valid = 1'b1;
                    rd_data  = pix_of(mem_addr[0]);
                    void'(mem_due.pop_front());
                    void'(mem_addr.pop_front());
                    outstanding--;
                end
                if (m_rdreq) begin
                    n_rd++;
                    outstanding++;
                    checks++;
                    if (outstanding > RDD) begin
                        errors++;
                        $display("FAIL outstanding got %0d limit %0d", outstanding, RDD);
                    end
                    checks++;
                    if (exp_rd.size() == 0) begin
                        errors++;
                        $display("FAIL rd_extra addr %h want none", m_rdaddr);
                    end else begin
                        if (m_rdaddr !== exp_rd[0]) begin
                            errors++;
                            $display("FAIL rd_addr got %h want %h", m_rdaddr, exp_rd[0]);
                        end
                        void'(exp_rd.pop_front());
                    end
                    mem_due.push_back(cyc + mem_lat);
                    mem_addr.push_back(m_rdaddr);
                end
                if (m_fvalid) begin
                    checks++;
                    if (exp_filt.size() == 0) begin
                        errors++;
                        $display("FAIL filt_extra got %h want none", m_fdata);
                    end else begin
                        if (m_fdata !== exp_filt[0]) begin
                            errors++;
                            $display("FAIL filt_data idx %0d got %h want %h", n_filt, m_fdata, exp_filt[0]);
                        end
                        void'(exp_filt.pop_front());
                        void'(exp_pix.pop_front());
                    end
                    if (n_filt >= fe_start && n_filt < fe_start + FILT_OUTS) begin
                        filt_valid = 1'b1;
                        filt_data  = 24'hF00000 | 24'(n_filt);
                        if (n_fo < NP) begin
                            exp_wa.push_back(cur_wr_base + AW'(n_fo));
                            exp_wd.push_back(filt_data);
                        end
                        n_fo++;
                    end
                    n_filt++;
                end else if (m_busy && exp_filt.size() > 0) begin
                    n_gap++;
                    checks++;
                    if (!exp_pix[0]) begin
                        errors++;
                        $display("FAIL filt_gap idx %0d got gap want pad zero", n_filt);
                    end
                end
                if (m_wrreq) begin
                    n_wr++;
                    checks++;
                    if (exp_wa.size() == 0) begin
                        errors++;
                        $display("FAIL wr_extra got %h/%h want none", m_wraddr, m_wrdata);
                    end else begin
                        if (m_wraddr !== exp_wa[0] || m_wrdata !== exp_wd[0]) begin
                            errors++;
                            $display("FAIL wr got %h/%h want %h/%h", m_wraddr, m_wrdata, exp_wa[0], exp_wd[0]);
                        end
                        void'(exp_wa.pop_front());
                        void'(exp_wd.pop_front());
                    end
                end
                if (m_done) begin
                    n_done++;
                    checks++;
                    if (m_busy !== 1'b0) begin
                        errors++;
                        $display("FAIL busy_at_done got %b want 0", m_busy);
                    end
                end
            end
        end
    end

    task automatic start_frame(input bit s, input logic [AW-1:0] rb, input logic [AW-1:0] wb,
                               input int lat);
        int b;
        int rl;
        sel = s; mem_lat = lat; cur_wr_base = wb;
        fe_start = s ? 3 : 8;
        exp_filt.delete(); exp_pix.delete(); exp_rd.delete(); exp_wa.delete(); exp_wd.delete();
        n_filt = 0; n_rd = 0; n_wr = 0; n_done = 0; n_fo = 0; n_gap = 0;
        b  = s ? 0 : 1;
        rl = W + 2 * b;
        for (int i = 0; i < b * rl; i++) begin exp_filt.push_back('0); exp_pix.push_back(1'b0); end
        for (int r = 0; r < H; r++) begin
            for (int i = 0; i < b; i++) begin exp_filt.push_back('0); exp_pix.push_back(1'b0); end
            for (int c = 0; c < W; c++) begin
                exp_filt.push_back(pix_of(rb + AW'(r * W + c)));
                exp_pix.push_back(1'b1);
            end
            for (int i = 0; i < b; i++) begin exp_filt.push_back('0); exp_pix.push_back(1'b0); end
        end
        for (int i = 0; i < b * rl + FL; i++) begin exp_filt.push_back('0); exp_pix.push_back(1'b0); end
        for (int i = 0; i < NP; i++) exp_rd.push_back(rb + AW'(i));
        rd_base_in = rb;
        wr_base_in = wb;
        if (s) start_b = 1'b1; else start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 3000 && !seen; i++) begin
            @(negedge clk);
            if (m_done === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s done_timeout got none want oDone", tag);
        end
    endtask

    task automatic end_checks(input string tag, input int exp_n, input int settle);
        repeat (settle) @(negedge clk);
        checks++;
        if (n_filt !== exp_n) begin errors++; $display("FAIL %s filt_count got %0d want %0d", tag, n_filt, exp_n); end
        checks++;
        if (n_rd !== NP) begin errors++; $display("FAIL %s rd_count got %0d want %0d", tag, n_rd, NP); end
        checks++;
        if (n_wr !== NP) begin errors++; $display("FAIL %s wr_count got %0d want %0d", tag, n_wr, NP); end
        checks++;
        if (n_done !== 1) begin errors++; $display("FAIL %s done_count got %0d want 1", tag, n_done); end
        checks++;
        if (exp_filt.size() != 0 || exp_rd.size() != 0 || exp_wa.size() != 0) begin
            errors++;
            $display("FAIL %s leftover got filt=%0d rd=%0d wr=%0d want 0", tag,
                     exp_filt.size(), exp_rd.size(), exp_wa.size());
        end
`ifdef FILTER_SEQ_STALL_CNT_EN
        checks++;
        if (m_stall !== 32'(n_gap)) begin errors++; $display("FAIL %s stall_cnt got %0d want %0d", tag, m_stall, n_gap); end
`endif
    endtask

    task automatic check_quiet(input string tag);
        logic [116:0] v;
        v = {m_rdreq, m_rdaddr, m_fvalid, m_fdata, m_wrreq, m_wraddr, m_wrdata, m_busy, m_done};
        checks++;
        if (v !== '0) begin errors++; $display("FAIL %s outputs got %h want 0", tag, v); end
`ifdef FILTER_SEQ_STALL_CNT_EN
        checks++;
        if (m_stall !== 32'd0) begin errors++; $display("FAIL %s stall_reset got %0d want 0", tag, m_stall); end
`endif
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        sel = 1'b0; #1; check_quiet("reset_k3");
        sel = 1'b1; #1; check_quiet("reset_k1");
        sel = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_stream_lat1();
        start_frame(1'b0, 32'h0000_1000, 32'h0000_8000, 1);
        wait_done("lat1");
        end_checks("lat1", 35, 6);
    endtask

    task automatic test_stream_lat7();
        start_frame(1'b0, 32'h0000_2040, 32'h0000_9000, 7);
        wait_done("lat7");
        end_checks("lat7", 35, 6);
    endtask

    task automatic test_write_wrap();
        start_frame(1'b0, 32'hFFFF_FFFA, 32'hFFFF_FFF8, 2);
        wait_done("wrap");
        end_checks("wrap", 35, 6);
    endtask

    task automatic test_back_to_back();
        start_frame(1'b0, 32'h0000_3000, 32'h0000_A000, 3);
        repeat (10) @(negedge clk);
        rd_base_in = 32'hDEAD_0000;
        wr_base_in = 32'hBEEF_0000;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        wait_done("restart_ignored");
        end_checks("restart_ignored", 35, 1);
        start_frame(1'b0, 32'h0000_3100, 32'h0000_A100, 1);
        wait_done("b2b_second");
        end_checks("b2b_second", 35, 6);
    endtask

    task automatic test_reset_midframe();
        bit hit = 1'b0;
        start_frame(1'b0, 32'h0000_4000, 32'h0000_C000, 1);
        for (int i = 0; i < 300 && !hit; i++) begin
            @(negedge clk);
            if (n_filt >= 20) hit = 1'b1;
        end
        checks++;
        if (!hit) begin errors++; $display("FAIL midreset_reach got %0d want >=20", n_filt); end
        reset = 1'b1;
        @(negedge clk);
        check_quiet("midreset_next");
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_quiet("midreset_idle");
        checks++;
        if (n_done !== 0) begin errors++; $display("FAIL midreset_done got %0d want 0", n_done); end
        start_frame(1'b0, 32'h0000_4400, 32'h0000_D000, 4);
        wait_done("after_reset");
        end_checks("after_reset", 35, 6);
    endtask

    task automatic test_k1();
        start_frame(1'b1, 32'h0000_5000, 32'h0000_E000, 7);
        wait_done("k1");
        end_checks("k1", NP + FL, 6);
`ifdef FILTER_SEQ_STALL_CNT_EN
        checks++;
        if (n_gap == 0) begin errors++; $display("FAIL k1_stalls got 0 want nonzero"); end
`endif
    endtask

    initial begin
        reset = 1'b1; start_a = 1'b0; start_b = 1'b0; sel = 1'b0;
        rd_base_in = '0; wr_base_in = '0; mem_lat = 1; fe_start = 8; cur_wr_base = '0;
        n_filt = 0; n_rd = 0; n_wr = 0; n_done = 0; n_fo = 0; n_gap = 0;
        @(negedge clk);
        test_reset();
        test_stream_lat1();
        test_stream_lat7();
        test_write_wrap();
        test_back_to_back();
        test_reset_midframe();
        test_k1();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got hang want finish");
        $fatal(1, "timeout");
    end

endmodule
